updown_counter_p: RTL and testbench
===================================

# updown_counter_p

Parametrised loadable up/down counter with a programmable prescaler and four terminal-count modes: wrap, saturate, one-shot and auto-reload. It replaces the fixed 8-bit up-only counter in datapath and timing blocks that need a width-configurable counter, event/timeout generation or periodic ticks. Load always takes priority over counting, and every terminal event is flagged with a single-cycle pulse.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- PRESCALE_W, 4, prescaler divisor width in bits (≥1)

- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  synchronous load of load_val into count and reload register
- load_val  in  WIDTH  load / reload value
- en  in  1  count enable; gates the prescaler
- up_dn  in  1  direction: 1 = up, 0 = down
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 auto-reload
- prescale  in  PRESCALE_W  divisor minus one; one step every prescale+1 enabled cycles
- count  out  WIDTH  current count
- tc  out  1  terminal-count pulse, one cycle per terminal event
- done  out  1  one-shot finished (state HALT)

## Operation
- Reset (async assert on rst_n low):
  - count = 0, reload register = 0, prescaler = 0, state = RUN, tc = 0, done = 0.
- Terminal value:
  - TERM = all-ones when up_dn = 1, zero when up_dn = 0.
  - Evaluated at each tick using the current up_dn.
- Prescaler:
  - Increments on cycles with en = 1.
  - When it equals prescale with en = 1, it asserts the internal tick and clears to 0.
  - When en = 0, it holds its value.
  - prescale = 0 produces a tick on every enabled cycle.
- Priority per cycle: load > tick > hold.
- Load:
  - count ← load_val and reload register ← load_val.
  - Prescaler cleared, state ← RUN, tc = 0.
  - No count step in that cycle, regardless of en.
- Tick in RUN with count ≠ TERM: count ± 1 by up_dn, tc = 0.
- Tick in RUN with count = TERM: tc = 1, then by mode:
  - wrap: modular step (0xFF→0x00 up, 0x00→0xFF down).
  - saturate: count holds; tc pulses on every such tick.
  - one-shot: count holds, state ← HALT.
  - auto-reload: count ← reload register.
- HALT state:
  - Ticks are ignored, count holds, tc = 0, done = 1.
  - Only load or reset leaves HALT.
  - Changing mode while in HALT does not exit HALT.
- State machine: RUN → HALT on a one-shot terminal tick; HALT → RUN on load.
- mode and up_dn may change at any time; changes take effect at the next tick.
- Arithmetic is unsigned, WIDTH bits, with no carry-out port.
- Boundary case: after reset in one-shot down mode, count = 0 = TERM, so the first tick halts immediately.

## Timing
- All outputs are registered.
- tc and the new count become visible together at the clock edge that ends the tick cycle.
- First step occurs prescale+1 enabled cycles after en rises, or after a load.
- load_val appears on count one cycle after load is sampled.
- rst_n is asynchronous on assertion. Deassertion must be synchronised externally to clk; no internal synchroniser.
- done rises in the same cycle as the final one-shot tc pulse and falls the cycle after load.

## Structure
- Shared package counter_pkg holds:
  - Mode encodings MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RELOAD.
  - State typedef (RUN, HALT).
- Sub-module tick_prescaler (parameter PRESCALE_W). Inputs: clk, rst_n, clr (driven by load), en, prescale. Output: tick.
- The top level holds the count register, reload register, state register and terminal logic.

## Test plan
- count = 0x05 mid-run, drive rst_n low between clock edges → count = 0x00, tc = 0, done = 0 immediately, without waiting for a clock.
- Wrap up, prescale 0: load 0xFE, en = 1, up_dn = 1 → count 0xFF, then 0x00 with tc = 1 on that cycle only, then 0x01.
- Saturate down, prescale 0: load 0x02 → count 0x01, 0x00; subsequent ticks hold 0x00 with tc = 1 each cycle.
- One-shot down, prescale 2: load 0x02 → count 0x01 after 3 cycles, 0x00 after 6, tc = 1 and done = 1 after 9 with count held at 0x00; further en has no effect; load 0x04 → done = 0, count = 0x04.
- Auto-reload up: load 0xFD → count 0xFE, 0xFF, then 0xFD with tc = 1, then 0xFE, repeating.
- Simultaneous load and tick: count = 0x10 at the tick cycle, load = 1, load_val = 0x80 → next count = 0x80, tc = 0, no step; next step lands 0x81 after prescale+1 enabled cycles.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter: terminal-count modes and FSM states.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_RELOAD  = 2'b11;

    typedef logic state_t;
    localparam state_t RUN  = 1'b0;
    localparam state_t HALT = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Purpose: divides enabled cycles by prescale+1 and emits a one-cycle tick.
// Latency: tick is combinational on the prescale+1-th enabled cycle after clr.
// Backpressure: none; en low freezes the divider, clr restarts it from zero.
module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] div_q;
    logic [PRESCALE_W-1:0] div_d;

    assign tick = en && (div_q == prescale);

    always_comb begin
        div_d = div_q;
        if (clr || tick) begin
            div_d = '0;
        end else if (en) begin
            div_d = div_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/updown_counter_p.sv
// Purpose: loadable up/down counter with prescaler and wrap/saturate/one-shot/reload terminal modes.
// Latency: load and steps appear on count one cycle after being sampled; tc/done registered alongside.
// Backpressure: none; en gates stepping, load always wins over a coincident tick.
module updown_counter_p
    import counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  done
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             tick;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    state_t           state_q, state_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] step;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (load),
        .en       (en),
        .prescale (prescale),
        .tick     (tick)
    );

    // Terminal value follows the direction in force at the tick.
    assign term = up_dn ? '1 : '0;
    assign step = up_dn ? (count_q + ONE) : (count_q - ONE);

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        state_d  = state_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = RUN;
        end else if (tick && (state_q == RUN)) begin
            if (count_q != term) begin
                count_d = step;
            end else begin
                tc_d = 1'b1;
                case (mode)
                    MODE_WRAP:    count_d = step;
                    MODE_SAT:     count_d = count_q;
                    MODE_ONESHOT: state_d = HALT;
                    default:      count_d = reload_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            reload_q <= '0;
            state_q  <= RUN;
            tc_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            state_q  <= state_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = (state_q == HALT);

endmodule

// File: tb/tb_updown_counter_p.sv
// Directed-vector bench: driver queues hand-computed outputs, a monitor checks each cycle.
module tb_updown_counter_p;

    localparam logic [1:0] WRAP = 2'b00;
    localparam logic [1:0] SAT  = 2'b01;
    localparam logic [1:0] ONES = 2'b10;
    localparam logic [1:0] RELD = 2'b11;

    typedef struct packed {
        logic [7:0] count;
        logic       tc;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic [1:0] mode = WRAP;
    logic [3:0] prescale = 4'd0;
    logic [7:0] count;
    logic       tc;
    logic       done;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    bit   finished = 1'b0;

    updown_counter_p #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up_dn    (up_dn),
        .mode     (mode),
        .prescale (prescale),
        .count    (count),
        .tc       (tc),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare against the queued expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cyc_n++;
            check($sformatf("cyc%0d count", cyc_n), int'(count), int'(e.count));
            check($sformatf("cyc%0d tc", cyc_n), int'(tc), int'(e.tc));
            check($sformatf("cyc%0d done", cyc_n), int'(done), int'(e.done));
        end
    end

    // Driver: called at a negedge; applies inputs, queues the post-edge expectation.
    task automatic cyc(input logic l, input logic [7:0] lv, input logic e, input logic ud,
                       input logic [1:0] m, input logic [3:0] ps,
                       input logic [7:0] ec, input logic etc, input logic ed);
        exp_t x;
        load = l; load_val = lv; en = e; up_dn = ud; mode = m; prescale = ps;
        @(posedge clk);
        x.count = ec; x.tc = etc; x.done = ed;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    // Async reset between edges; outputs must clear without a clock.
    task automatic reset_pulse(input string name);
        load = 1'b0; en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check({name, " count"}, int'(count), 0);
        check({name, " tc"}, int'(tc), 0);
        check({name, " done"}, int'(done), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        if (!finished) begin
            errors++;
            $display("FAIL timeout: got running expected finished");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        @(negedge clk);
        check("rst count", int'(count), 0);
        check("rst tc", int'(tc), 0);
        check("rst done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-run
        cyc(1, 8'h03, 0, 1, WRAP, 0, 8'h03, 0, 0);
        cyc(0, 8'h00, 1, 1, WRAP, 0, 8'h04, 0, 0);
        cyc(0, 8'h00, 1, 1, WRAP, 0, 8'h05, 0, 0);
        reset_pulse("midrun rst");

        // Wrap up then down, prescale 0
        cyc(1, 8'hFE, 1, 1, WRAP, 0, 8'hFE, 0, 0);
        cyc(0, 8'h00, 1, 1, WRAP, 0, 8'hFF, 0, 0);
        cyc(0, 8'h00, 1, 1, WRAP, 0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 1, WRAP, 0, 8'h01, 0, 0);
        cyc(0, 8'h00, 1, 0, WRAP, 0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0, WRAP, 0, 8'hFF, 1, 0);

        // Saturate down
        cyc(1, 8'h02, 1, 0, SAT, 0, 8'h02, 0, 0);
        cyc(0, 8'h00, 1, 0, SAT, 0, 8'h01, 0, 0);
        cyc(0, 8'h00, 1, 0, SAT, 0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0, SAT, 0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0, SAT, 0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0, SAT, 0, 8'h00, 0, 0);

        // One-shot down, prescale 2
        cyc(1, 8'h02, 1, 0, ONES, 2, 8'h02, 0, 0);
        cyc(0, 8'h00, 1, 0, ONES, 2, 8'h02, 0, 0);
        cyc(0, 8'h00, 1, 0, ONES, 2, 8'h02, 0, 0);
        cyc(0, 8'h00, 1, 0, ONES, 2, 8'h01, 0, 0);
        cyc(0, 8'h00, 1, 0, ONES, 2, 8'h01, 0, 0);
        cyc(0, 8'h00, 1, 0, ONES, 2, 8'h01, 0, 0);
        cyc(0, 8'h00, 1, 0, ONES, 2, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0, ONES, 2, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0, ONES, 2, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0, ONES, 2, 8'h00, 1, 1);
        // Halted: mode change to wrap and further ticks must not move it
        cyc(0, 8'h00, 1, 0, WRAP, 2, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 0, WRAP, 2, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 0, WRAP, 2, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 0, WRAP, 2, 8'h00, 0, 1);
        cyc(1, 8'h04, 1, 0, ONES, 2, 8'h04, 0, 0);

        // Auto-reload up
        cyc(1, 8'hFD, 1, 1, RELD, 0, 8'hFD, 0, 0);
        cyc(0, 8'h00, 1, 1, RELD, 0, 8'hFE, 0, 0);
        cyc(0, 8'h00, 1, 1, RELD, 0, 8'hFF, 0, 0);
        cyc(0, 8'h00, 1, 1, RELD, 0, 8'hFD, 1, 0);
        cyc(0, 8'h00, 1, 1, RELD, 0, 8'hFE, 0, 0);
        cyc(0, 8'h00, 1, 1, RELD, 0, 8'hFF, 0, 0);
        cyc(0, 8'h00, 1, 1, RELD, 0, 8'hFD, 1, 0);

        // Load coinciding with a tick, prescale 1
        cyc(1, 8'h0F, 1, 1, WRAP, 1, 8'h0F, 0, 0);
        cyc(0, 8'h00, 1, 1, WRAP, 1, 8'h0F, 0, 0);
        cyc(0, 8'h00, 1, 1, WRAP, 1, 8'h10, 0, 0);
        cyc(0, 8'h00, 1, 1, WRAP, 1, 8'h10, 0, 0);
        cyc(1, 8'h80, 1, 1, WRAP, 1, 8'h80, 0, 0);
        cyc(0, 8'h00, 1, 1, WRAP, 1, 8'h80, 0, 0);
        cyc(0, 8'h00, 1, 1, WRAP, 1, 8'h81, 0, 0);

        // Load at terminal with a tick pending suppresses tc
        cyc(1, 8'hFF, 1, 1, SAT, 0, 8'hFF, 0, 0);
        cyc(1, 8'hFF, 1, 1, SAT, 0, 8'hFF, 0, 0);
        cyc(0, 8'h00, 1, 1, SAT, 0, 8'hFF, 1, 0);

        // One-shot down straight out of reset halts on the first tick
        reset_pulse("pre oneshot rst");
        cyc(0, 8'h00, 1, 0, ONES, 0, 8'h00, 1, 1);
        cyc(0, 8'h00, 1, 0, ONES, 0, 8'h00, 0, 1);
        reset_pulse("halt rst");

        load = 1'b0; en = 1'b0;
        repeat (2) @(negedge clk);
        check("queue drained", exp_q.size(), 0);
        finished = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
